// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUCtl encodings and decode helpers for the EX-stage ALU.
// The ALU control decoder and the execute unit both import this package so the encodings live in one place.
package alu_exec_unit_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_SLLV = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_SRAV = 4'd13;
  localparam logic [3:0] ALU_RSVD = 4'd14;
  localparam logic [3:0] ALU_LINK = 4'd15;

  typedef struct packed {
    logic right;
    logic arith;
  } shift_mode_t;

  function automatic logic is_shift(input logic [3:0] c);
    return (c == ALU_SLL) || (c == ALU_SLLV) || (c == ALU_SRL) ||
           (c == ALU_SRLV) || (c == ALU_SRA) || (c == ALU_SRAV);
  endfunction

  function automatic logic is_var_shift(input logic [3:0] c);
    return (c == ALU_SLLV) || (c == ALU_SRLV) || (c == ALU_SRAV);
  endfunction

  function automatic shift_mode_t shift_mode(input logic [3:0] c);
    shift_mode_t m;
    m.right = (c == ALU_SRL) || (c == ALU_SRLV) || (c == ALU_SRA) || (c == ALU_SRAV);
    m.arith = (c == ALU_SRA) || (c == ALU_SRAV);
    return m;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative barrel-free shifter: moves at most STEP bit positions per cycle until the amount is consumed.
module alu_serial_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               start,
  input  shift_mode_t        mode,
  input  logic [DATA_W-1:0]  value,
  input  logic [SHAMT_W-1:0] amount,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  shifted
);

  localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);

  logic [DATA_W-1:0]  work, work_next;
  logic [SHAMT_W-1:0] rem, step;
  shift_mode_t        mode_q;

  assign step = (rem < STEP_L) ? rem : STEP_L;
  // The final step always consumes rem exactly, so done coincides with rem reaching zero.
  assign done    = busy && (rem <= STEP_L);
  assign shifted = work_next;

  always_comb begin
    work_next = work;
    if (!mode_q.right)     work_next = work << step;
    else if (mode_q.arith) work_next = $signed(work) >>> step;
    else                   work_next = work >> step;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy   <= 1'b0;
      work   <= '0;
      rem    <= '0;
      mode_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      work   <= value;
      rem    <= amount;
      mode_q <= mode;
    end else if (busy) begin
      work <= work_next;
      rem  <= rem - step;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle logic/arith ops, multi-cycle shifts, valid/ready result register.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctl,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  link_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               bad_op
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e             state, state_next;
  logic               accept, shift_go;
  logic [SHAMT_W-1:0] amount;
  logic [DATA_W-1:0]  alu_res, sh_res;
  logic               alu_bad, sh_busy, sh_done;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign amount   = is_var_shift(alu_ctl) ? op_a[SHAMT_W-1:0] : shamt;
  // A zero-amount shift takes the single-cycle path and returns op_b unchanged.
  assign shift_go = accept && is_shift(alu_ctl) && (amount != '0);

  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    case (alu_ctl)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_LUI:  alu_res = op_b << 16;
      ALU_SLL, ALU_SLLV, ALU_SRL, ALU_SRLV, ALU_SRA, ALU_SRAV:
                alu_res = op_b;
      ALU_RSVD: alu_bad = 1'b1;
      ALU_LINK: alu_res = link_addr;
      default:  alu_res = '0;
    endcase
  end

  alu_serial_shifter #(.DATA_W(DATA_W), .STEP(SHIFT_STEP)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .start   (shift_go),
    .mode    (shift_mode(alu_ctl)),
    .value   (op_b),
    .amount  (amount),
    .busy    (sh_busy),
    .done    (sh_done),
    .shifted (sh_res)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (shift_go) state_next = S_SHIFT;
      S_SHIFT: if (sh_done || !sh_busy) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Pop and reload may happen on the same edge; the reload wins so 1-cycle ops stream back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      bad_op    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !shift_go) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        bad_op    <= alu_bad;
      end else if (sh_done) begin
        out_valid <= 1'b1;
        result    <= sh_res;
        zero      <= (sh_res == '0);
        bad_op    <= 1'b0;
      end
    end
  end

endmodule
